lc3b_mem_arbiter: RTL and testbench
===================================

// Module: lc3b_mem_arbiter
// PURPOSE
//  Memory-side responder for the pipelined LC-3b datapath's two line ports: IF fetch and MEM load/store.
//  Accepts 128-bit line requests from both ports and arbitrates them onto one physical memory port.
//  Returns the line and a one-cycle resp pulse to the port that was served.
//  Sits between the datapath/L1 request ports and the single pmem interface.
// PARAMETERS
//  ADDR_WIDTH   16   byte address width (lc3b_word)
//  LINE_WIDTH   128  line data width (lc3b_line)
//  OFFSET_BITS  4    byte-offset bits per line; forced to 0 on pmem_address
// PORTS
//  clk            in   1    rising-edge clock
//  reset_n        in   1    asynchronous, active-low reset
//  i_read         in   1    fetch-port line read request; held until i_resp
//  i_address      in   16   fetch byte address
//  i_rdata        out  128  fetch line data; valid when i_resp=1
//  i_resp         out  1    fetch done, one-cycle pulse
//  d_read         in   1    data-port line read request; held until d_resp
//  d_write        in   1    data-port line write request; held until d_resp
//  d_address      in   16   data byte address
//  d_wdata        in   128  data line write data (pre-shifted by requester)
//  d_rdata        out  128  data line read data; valid when d_resp=1
//  d_resp         out  1    data done, one-cycle pulse
//  pmem_read      out  1    physical read strobe, held until pmem_resp
//  pmem_write     out  1    physical write strobe, held until pmem_resp
//  pmem_address   out  16   line-aligned address {addr[15:4],4'b0}
//  pmem_wdata     out  128  physical write data
//  pmem_rdata     in   128  physical read data; valid with pmem_resp
//  pmem_resp      in   1    physical transaction done, single-cycle
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, last_grant=I.
//    Latched address and wdata =0. pmem_read/pmem_write/i_resp/d_resp =0.
//  - FSM states IDLE, I_BUSY, D_BUSY. All state changes are registered on clk.
//  - IDLE: samples requests each cycle. Data request = d_read|d_write.
//    - Only one port requesting: grant that port.
//    - Both requesting: grant the port != last_grant (round-robin). After reset, data wins first.
//    - On grant: latch line-aligned address, d_wdata and op (d_write dominates if d_read&d_write).
//      Set last_grant, go to I_BUSY/D_BUSY.
//  - BUSY: pmem_read or pmem_write =1 from the registered op. Strobe begins the cycle after the grant.
//  - In BUSY with pmem_resp=1: x_resp=pmem_resp (combinational, same cycle).
//    x_rdata=pmem_rdata passthrough. Next state IDLE.
//  - Non-served port: its resp stays 0 and its rdata is don't-care.
//  - Latency: request in IDLE at cycle N -> pmem strobe at N+1 -> resp in the cycle pmem_resp arrives.
//    Minimum request-to-resp is 2 cycles.
//  - Back-to-back: requester drops its request the cycle after resp; the following IDLE cycle sees the new level.
//    A request still held in that IDLE cycle is treated as new and served again (e.g. pipelined fetch with new pc).
//  - Request withdrawn mid-BUSY: pmem transaction runs to completion; resp still pulses and is ignored.
//  - Inputs changing mid-BUSY: no effect; pmem outputs come from the latched values.
//  - pmem_resp while IDLE: ignored; no resp is generated.
//  - Reset asserted mid-transaction: strobes drop immediately (async). pmem must abort.
//  - Only one pmem transaction is ever outstanding; pmem_read&pmem_write is never 1.
// STRUCTURE
//  - Package lc3b_types:
//    - adds lc3b_arb_state enum {IDLE, I_BUSY, D_BUSY};
//    - adds lc3b_offset_bits=4;
//    - reuses lc3b_word and lc3b_line.
//  - Latches use the existing register module (width 16 and 128). No new sub-module.
//  - The FSM is a single always_ff with async reset plus an always_comb next-state/output block.
// TESTING
//  1. Reset: drive reset_n=0 mid-D_BUSY -> pmem_write=0 at once.
//     After release, state IDLE and all outputs 0.
//  2. Fetch only: i_read=1, i_address=16'h1236; pmem returns after 3 cycles with line L.
//     -> pmem_address=16'h1230; i_resp one cycle with i_rdata=L; d_resp=0.
//  3. Write only: d_write=1, d_address=16'h0042, d_wdata=W.
//     -> pmem_write=1, pmem_address=16'h0040, pmem_wdata=W; d_resp pulses once.
//  4. Contention: i_read and d_read both held from reset.
//     -> grant order D, I, D, I over four transactions; no port starves.
//  5. Hazards:
//     - d_read&d_write -> write only.
//     - Stray pmem_resp in IDLE -> no resp.
//     - d_address changed mid-BUSY -> pmem_address unchanged.
//  6. Random: random request/drop patterns, pmem latency 1-8 cycles.
//     -> scoreboard matches every resp to the correct port/data; never two strobes at once.

Source files
------------

// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types for the LC-3b line-port memory arbiter: word/line types, FSM states,
// port identifiers and line-alignment helper.
package lc3b_mem_arbiter_pkg;

   localparam int unsigned lc3b_addr_width = 16;
   localparam int unsigned lc3b_line_width = 128;
   localparam int unsigned lc3b_offset_bits = 4;

   typedef logic [lc3b_addr_width-1:0] lc3b_word;
   typedef logic [lc3b_line_width-1:0] lc3b_line;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } lc3b_arb_state;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } lc3b_port_e;

   // Clears the byte-offset bits so pmem always sees a line-aligned address.
   function automatic lc3b_word lc3b_line_align(lc3b_word addr);
      return addr & ~lc3b_word'((32'd1 << lc3b_offset_bits) - 32'd1);
   endfunction

endpackage

// File: rtl/lc3b_mem_arbiter_if.sv
// Bundles the fetch port, data port and physical memory port seen by the arbiter.
interface lc3b_mem_arbiter_if;
   import lc3b_mem_arbiter_pkg::*;

   logic     i_read;
   lc3b_word i_address;
   lc3b_line i_rdata;
   logic     i_resp;

   logic     d_read;
   logic     d_write;
   lc3b_word d_address;
   lc3b_line d_wdata;
   lc3b_line d_rdata;
   logic     d_resp;

   logic     pmem_read;
   logic     pmem_write;
   lc3b_word pmem_address;
   lc3b_line pmem_wdata;
   lc3b_line pmem_rdata;
   logic     pmem_resp;

   // Arbiter side.
   modport slave (
      input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   // Requesters plus physical memory side.
   modport master (
      output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );

endinterface

// File: rtl/lc3b_mem_arbiter_register.sv
// Loadable register with asynchronous active-low clear, used for the latched address and data.
module lc3b_mem_arbiter_register #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_in,
   output logic [WIDTH-1:0] o_out
);

   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_in;
      end
   end

   assign o_out = r_data;

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Round-robin arbiter putting the LC-3b fetch and data line ports onto one physical memory port;
// one transaction outstanding at a time, resp passed straight through from pmem.
module lc3b_mem_arbiter
   import lc3b_mem_arbiter_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset_n,
   lc3b_mem_arbiter_if.slave         mem
);

   lc3b_arb_state r_state;
   lc3b_arb_state w_state_next;
   lc3b_port_e    r_last_grant;
   lc3b_port_e    w_last_grant_next;
   logic          r_op_write;
   logic          w_op_write_next;

   logic          w_d_req;
   logic          w_grant;
   logic          w_grant_d;
   lc3b_word      w_addr_sel;
   lc3b_word      w_addr_aligned;
   lc3b_word      w_addr_q;
   lc3b_line      w_wdata_q;

   // Data wins a tie unless it was the last port served.
   always_comb begin
      w_d_req        = mem.d_read | mem.d_write;
      w_grant        = (r_state == IDLE) && (w_d_req || mem.i_read);
      w_grant_d      = w_d_req && (!mem.i_read || (r_last_grant == GRANT_I));
      w_addr_sel     = w_grant_d ? mem.d_address : mem.i_address;
      w_addr_aligned = lc3b_line_align(w_addr_sel);
   end

   lc3b_mem_arbiter_register #(
      .WIDTH (lc3b_addr_width)
   ) u_addr_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_grant),
      .i_in    (w_addr_aligned),
      .o_out   (w_addr_q)
   );

   lc3b_mem_arbiter_register #(
      .WIDTH (lc3b_line_width)
   ) u_wdata_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_grant),
      .i_in    (mem.d_wdata),
      .o_out   (w_wdata_q)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_last_grant <= GRANT_I;
         r_op_write   <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_last_grant <= w_last_grant_next;
         r_op_write   <= w_op_write_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_last_grant_next = r_last_grant;
      w_op_write_next   = r_op_write;
      mem.pmem_read     = 1'b0;
      mem.pmem_write    = 1'b0;
      mem.i_resp        = 1'b0;
      mem.d_resp        = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (w_grant) begin
               w_state_next      = w_grant_d ? D_BUSY : I_BUSY;
               w_last_grant_next = w_grant_d ? GRANT_D : GRANT_I;
               // A combined read+write request is treated as a write.
               w_op_write_next   = w_grant_d & mem.d_write;
            end
         end
         I_BUSY: begin
            mem.pmem_read  = ~r_op_write;
            mem.pmem_write = r_op_write;
            mem.i_resp     = mem.pmem_resp;
            if (mem.pmem_resp) begin
               w_state_next = IDLE;
            end
         end
         D_BUSY: begin
            mem.pmem_read  = ~r_op_write;
            mem.pmem_write = r_op_write;
            mem.d_resp     = mem.pmem_resp;
            if (mem.pmem_resp) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign mem.pmem_address = w_addr_q;
   assign mem.pmem_wdata   = w_wdata_q;
   assign mem.i_rdata      = mem.pmem_rdata;
   assign mem.d_rdata      = mem.pmem_rdata;

   a_one_strobe: assert property (@(posedge clk) disable iff (!reset_n)
      !(mem.pmem_read && mem.pmem_write));

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin model.
module tb_lc3b_mem_arbiter;
   import lc3b_mem_arbiter_pkg::*;

   logic clk;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   lc3b_mem_arbiter_if bus ();

   lc3b_mem_arbiter dut (
      .clk     (clk),
      .reset_n (reset_n),
      .mem     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=<2ms", $time);
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      bus.i_read     = 1'b0;
      bus.i_address  = '0;
      bus.d_read     = 1'b0;
      bus.d_write    = 1'b0;
      bus.d_address  = '0;
      bus.d_wdata    = '0;
      bus.pmem_rdata = '0;
      bus.pmem_resp  = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      lc3b_line w;
      clear_inputs();
      reset_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobes: rd=%b wr=%b required 0 0", bus.pmem_read, bus.pmem_write);
      end
      checks++;
      if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
         errors++;
         $display("FAIL reset_resp: i=%b d=%b required 0 0", bus.i_resp, bus.d_resp);
      end
      checks++;
      if (bus.pmem_address !== 16'h0 || bus.pmem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_latches: addr=%h wdata=%h required 0", bus.pmem_address,
                  bus.pmem_wdata);
      end
      reset_n = 1'b1;
      // Reset asserted in the middle of a write transaction.
      w = {$urandom, $urandom, $urandom, $urandom};
      bus.d_write   = 1'b1;
      bus.d_address = 16'h0100;
      bus.d_wdata   = w;
      tick();
      checks++;
      if (bus.pmem_write !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_busy: pmem_write=%b required 1", bus.pmem_write);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b0) begin
         errors++;
         $display("FAIL reset_async_drop: rd=%b wr=%b required 0 0", bus.pmem_read,
                  bus.pmem_write);
      end
      bus.d_write = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      checks++;
      if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || bus.i_resp !== 1'b0 ||
          bus.d_resp !== 1'b0 || bus.pmem_address !== 16'h0 || bus.pmem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_release_idle: rd=%b wr=%b iresp=%b dresp=%b addr=%h required all 0",
                  bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, bus.pmem_address);
      end
   endtask

   task automatic test_fetch();
      lc3b_line l;
      clear_inputs();
      do_reset();
      l = {$urandom, $urandom, $urandom, $urandom};
      bus.i_read    = 1'b1;
      bus.i_address = 16'h1236;
      tick();
      checks++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_address !== 16'h1230) begin
         errors++;
         $display("FAIL fetch_strobe: rd=%b wr=%b addr=%h required 1 0 1230", bus.pmem_read,
                  bus.pmem_write, bus.pmem_address);
      end
      checks++;
      if (bus.i_resp !== 1'b0) begin
         errors++;
         $display("FAIL fetch_early_resp: i_resp=%b required 0", bus.i_resp);
      end
      tick();
      tick();
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = l;
      #1;
      checks++;
      if (bus.i_resp !== 1'b1 || bus.i_rdata !== l || bus.d_resp !== 1'b0) begin
         errors++;
         $display("FAIL fetch_resp: i_resp=%b d_resp=%b i_rdata=%h required 1 0 %h", bus.i_resp,
                  bus.d_resp, bus.i_rdata, l);
      end
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      bus.i_read    = 1'b0;
      #1;
      checks++;
      if (bus.i_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin
         errors++;
         $display("FAIL fetch_done: i_resp=%b pmem_read=%b required 0 0", bus.i_resp,
                  bus.pmem_read);
      end
   endtask

   task automatic test_write();
      lc3b_line w;
      int       pulses;
      clear_inputs();
      do_reset();
      w = {$urandom, $urandom, $urandom, $urandom};
      bus.d_write   = 1'b1;
      bus.d_address = 16'h0042;
      bus.d_wdata   = w;
      tick();
      checks++;
      if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_address !== 16'h0040 ||
          bus.pmem_wdata !== w) begin
         errors++;
         $display("FAIL write_strobe: wr=%b rd=%b addr=%h wdata=%h required 1 0 0040 %h",
                  bus.pmem_write, bus.pmem_read, bus.pmem_address, bus.pmem_wdata, w);
      end
      pulses = 0;
      bus.pmem_resp = 1'b1;
      #1;
      if (bus.d_resp === 1'b1) pulses++;
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      bus.d_write   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (bus.d_resp === 1'b1) pulses++;
         tick();
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL write_resp_pulses: got=%0d required 1", pulses);
      end
      checks++;
      if (bus.pmem_write !== 1'b0) begin
         errors++;
         $display("FAIL write_idle: pmem_write=%b required 0", bus.pmem_write);
      end
   endtask

   task automatic test_contention();
      bit       exp_d;
      bit       seen;
      lc3b_word exp_addr;
      clear_inputs();
      bus.i_read    = 1'b1;
      bus.i_address = 16'h1114;
      bus.d_read    = 1'b1;
      bus.d_address = 16'h2228;
      do_reset();
      for (int t = 0; t < 4; t++) begin
         exp_d    = (t % 2 == 0);
         exp_addr = exp_d ? 16'h2220 : 16'h1110;
         seen     = 1'b0;
         for (int c = 0; c < 6 && !seen; c++) begin
            tick();
            if (bus.pmem_read === 1'b1) seen = 1'b1;
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL contention_timeout: txn=%0d no strobe, required strobe", t);
         end else begin
            checks++;
            if (bus.pmem_address !== exp_addr) begin
               errors++;
               $display("FAIL contention_order: txn=%0d addr=%h required %h", t,
                        bus.pmem_address, exp_addr);
            end
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = {4{$urandom}};
            #1;
            checks++;
            if (bus.d_resp !== exp_d || bus.i_resp !== !exp_d) begin
               errors++;
               $display("FAIL contention_resp: txn=%0d i=%b d=%b required i=%b d=%b", t,
                        bus.i_resp, bus.d_resp, !exp_d, exp_d);
            end
            @(posedge clk); #1;
            bus.pmem_resp = 1'b0;
         end
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_hazards();
      clear_inputs();
      do_reset();
      // Read and write together resolve to a write.
      bus.d_read    = 1'b1;
      bus.d_write   = 1'b1;
      bus.d_address = 16'h0317;
      tick();
      checks++;
      if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin
         errors++;
         $display("FAIL hazard_rw_write: wr=%b rd=%b required 1 0", bus.pmem_write,
                  bus.pmem_read);
      end
      bus.pmem_resp = 1'b1;
      #1;
      checks++;
      if (bus.d_resp !== 1'b1) begin
         errors++;
         $display("FAIL hazard_rw_resp: d_resp=%b required 1", bus.d_resp);
      end
      @(posedge clk); #1;
      clear_inputs();
      tick();
      // Stray pmem_resp with nothing outstanding.
      bus.pmem_resp = 1'b1;
      #1;
      checks++;
      if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
         errors++;
         $display("FAIL hazard_stray_resp: i=%b d=%b required 0 0", bus.i_resp, bus.d_resp);
      end
      tick();
      bus.pmem_resp = 1'b0;
      checks++;
      if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
         errors++;
         $display("FAIL hazard_stray_idle: rd=%b wr=%b required 0 0", bus.pmem_read,
                  bus.pmem_write);
      end
      // Address change while busy must not reach pmem.
      bus.d_read    = 1'b1;
      bus.d_address = 16'h5678;
      tick();
      bus.d_address = 16'hABCD;
      bus.d_wdata   = {4{32'hDEADBEEF}};
      tick();
      checks++;
      if (bus.pmem_address !== 16'h5670 || bus.pmem_read !== 1'b1) begin
         errors++;
         $display("FAIL hazard_addr_hold: addr=%h rd=%b required 5670 1", bus.pmem_address,
                  bus.pmem_read);
      end
      bus.pmem_resp = 1'b1;
      @(posedge clk); #1;
      clear_inputs();
      tick();
   endtask

   task automatic test_random();
      bit       m_busy;
      bit       m_port;
      bit       m_write;
      bit       m_last;
      lc3b_word m_addr;
      lc3b_line m_wdata;
      int       lat;
      int       cnt;
      bit       i_done;
      bit       d_done;
      bit       exp_i;
      bit       exp_d;
      bit       d_req;
      int unsigned op;
      clear_inputs();
      do_reset();
      m_busy = 1'b0;
      m_port = 1'b0;
      m_write = 1'b0;
      m_last = 1'b0;
      m_addr = '0;
      m_wdata = '0;
      lat = 0;
      cnt = 0;
      i_done = 1'b0;
      d_done = 1'b0;
      for (int c = 0; c < 600; c++) begin
         // Requesters.
         if (i_done || (bus.i_read && ($urandom % 16 == 0))) begin
            bus.i_read = 1'b0;
         end else if (!bus.i_read && ($urandom % 3 == 0)) begin
            bus.i_read    = 1'b1;
            bus.i_address = 16'($urandom);
         end
         d_req = bus.d_read | bus.d_write;
         if (d_done || (d_req && ($urandom % 16 == 0))) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
         end else if (!d_req && ($urandom % 3 == 0)) begin
            op = $urandom % 3;
            bus.d_read    = (op != 1);
            bus.d_write   = (op != 0);
            bus.d_address = 16'($urandom);
            bus.d_wdata   = {$urandom, $urandom, $urandom, $urandom};
         end else if (m_busy && m_port && ($urandom % 4 == 0)) begin
            bus.d_address = 16'($urandom);
            bus.d_wdata   = {$urandom, $urandom, $urandom, $urandom};
         end
         // Physical memory.
         bus.pmem_resp  = m_busy ? (cnt == lat) : ($urandom % 10 == 0);
         bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
         #1;
         exp_i = m_busy && bus.pmem_resp && !m_port;
         exp_d = m_busy && bus.pmem_resp && m_port;
         checks++;
         if (bus.i_resp !== exp_i || bus.d_resp !== exp_d) begin
            errors++;
            $display("FAIL random_resp: cyc=%0d i=%b d=%b required i=%b d=%b", c, bus.i_resp,
                     bus.d_resp, exp_i, exp_d);
         end
         if (exp_i || exp_d) begin
            checks++;
            if ((exp_i ? bus.i_rdata : bus.d_rdata) !== bus.pmem_rdata) begin
               errors++;
               $display("FAIL random_rdata: cyc=%0d got=%h required %h", c,
                        exp_i ? bus.i_rdata : bus.d_rdata, bus.pmem_rdata);
            end
         end
         i_done = exp_i;
         d_done = exp_d;
         // Transaction model for the coming clock edge.
         if (m_busy) begin
            if (bus.pmem_resp) m_busy = 1'b0;
            else cnt++;
         end else if ((bus.d_read | bus.d_write) || bus.i_read) begin
            m_port  = (bus.d_read | bus.d_write) && (!bus.i_read || !m_last);
            m_busy  = 1'b1;
            m_write = m_port && bus.d_write;
            m_addr  = (m_port ? bus.d_address : bus.i_address) & 16'hFFF0;
            m_wdata = bus.d_wdata;
            m_last  = m_port;
            lat     = $urandom_range(1, 8);
            cnt     = 1;
         end
         @(posedge clk); #1;
         checks++;
         if (bus.pmem_read !== (m_busy && !m_write) || bus.pmem_write !== (m_busy && m_write)) begin
            errors++;
            $display("FAIL random_strobe: cyc=%0d rd=%b wr=%b required rd=%b wr=%b", c,
                     bus.pmem_read, bus.pmem_write, m_busy && !m_write, m_busy && m_write);
         end
         if (m_busy) begin
            checks++;
            if (bus.pmem_address !== m_addr || (m_write && bus.pmem_wdata !== m_wdata)) begin
               errors++;
               $display("FAIL random_payload: cyc=%0d addr=%h wdata=%h required %h %h", c,
                        bus.pmem_address, bus.pmem_wdata, m_addr, m_wdata);
            end
         end
      end
      clear_inputs();
      tick();
   endtask

   initial begin
      reset_n = 1'b0;
      clear_inputs();
      test_reset();
      test_fetch();
      test_write();
      test_contention();
      test_hazards();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
